fifo_1: RTL and testbench

FIFO_1 -- requirements
Module: fifo_1

---
 rtl/fifo_1_pkg.sv | 6 +
 rtl/fifo_1_mem.sv | 30 +++
 rtl/fifo_1.sv | 61 ++++++
 tb/tb_fifo_1.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fifo_1_pkg.sv
// Shared sizing defaults for the fifo_1 block and its storage.
package fifo_1_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);
endpackage

// File: rtl/fifo_1_mem.sv
// DEPTH x DATA_W storage: synchronous write, registered read (1-cycle latency).
// Only the read register is reset; the array never is.
module fifo_1_mem
  import fifo_1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_dat
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Read-before-write on a shared address: a full FIFO doing push+pull gets the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_1.sv
// Synchronous FIFO: 1-cycle registered read, flags decoded from the occupancy count.
// Push while full is dropped unless paired with a pull; pull while empty is ignored.
module fifo_1
  import fifo_1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              push_i,
  input  logic              pull_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pull_ok;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign pull_ok = pull_i && !empty_o;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign push_ok = push_i && (!full_o || pull_ok);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pull_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pull_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_1_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_dat  (data_i),
    .rd_en   (pull_ok),
    .rd_addr (rd_ptr),
    .rd_dat  (data_o)
  );
endmodule

// File: tb/tb_fifo_1.sv
// Directed and randomized checks of fifo_1 against a queue-based reference model.
module tb_fifo_1;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = '0;
  logic        push = 1'b0;
  logic        pull = 1'b0;
  logic [31:0] data_o;
  logic        full_o;
  logic        empty_o;

  logic [31:0] model[$];
  logic [31:0] exp_dat = '0;
  int          vectors = 0;
  int          miscompares = 0;

  fifo_1 dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (din),
    .push_i  (push),
    .pull_i  (pull),
    .data_o  (data_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("data_o", data_o, exp_dat);
    check("empty_o", {31'd0, empty_o}, {31'd0, model.size() == 0});
    check("full_o", {31'd0, full_o}, {31'd0, model.size() == DEPTH});
  endtask

  // One clock edge with the given request; the model decides acceptance from its own occupancy.
  task automatic step(input logic p, input logic l, input logic [31:0] d);
    int   cnt;
    logic lok;
    logic pok;
    push = p;
    pull = l;
    din  = d;
    cnt  = model.size();
    lok  = l && (cnt > 0);
    pok  = p && ((cnt < DEPTH) || lok);
    @(posedge clk);
    #1;
    if (lok) exp_dat = model.pop_front();
    if (pok) model.push_back(d);
    push = 1'b0;
    pull = 1'b0;
    check_all();
  endtask

  initial begin
    logic [31:0] v;
    // Reset held, then released
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0);

    // Single push/pull of 3, then pull while empty, then 7 through
    step(1'b1, 1'b0, 32'd3);
    step(1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 32'd7);
    step(1'b0, 1'b1, 32'd0);

    // Two-deep ordering
    step(1'b1, 1'b0, 32'd5);
    step(1'b1, 1'b0, 32'd9);
    step(1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 32'd0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b1, 1'b0, 32'd99);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 32'd0);

    // Full with simultaneous push+pull keeps full and ordering
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(100 + i));
    step(1'b1, 1'b1, 32'd200);
    step(1'b0, 1'b1, 32'd0);

    // Steady 15 entries with push+pull across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      step(1'b1, 1'b1, v);
    end

    // Random traffic with alternating fill/drain bias
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        v = $urandom;
        step($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30),
             $urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75), v);
      end
    end

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(300 + i));
    #2;
    rst = 1'b0;
    #1;
    model.delete();
    exp_dat = '0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 32'd42);
    step(1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
